// File: rtl/ip_upscale.sv
// Input-side width converter for the CORDIC core: sign-extends and left-aligns x/y samples, then
// buffers them in a 2-entry valid/ready FIFO. Optional 180-degree pre-rotation: IP_UPSCALE_PREROT_EN.
module ip_upscale #(
  parameter int CORDIC_WIDTH = 22,
  parameter int DATA_WIDTH   = 16,
  parameter int GUARD_BITS   = 2
) (
  input  logic                    clk,
  input  logic                    nreset,
  input  logic                    clr,
  input  logic [DATA_WIDTH-1:0]   x_in,
  input  logic [DATA_WIDTH-1:0]   y_in,
  input  logic                    ip_vld,
  output logic                    ip_rdy,
  output logic [CORDIC_WIDTH-1:0] x_out,
  output logic [CORDIC_WIDTH-1:0] y_out,
  output logic                    quad_out,
  output logic                    op_vld,
  input  logic                    op_rdy
);

  localparam int SHIFT = CORDIC_WIDTH - DATA_WIDTH - GUARD_BITS;

  typedef logic signed [CORDIC_WIDTH-1:0] word_t;

  // Handshake contract: a sample moves on a cycle where valid and ready are both high; ip_rdy and
  // op_vld decode registered state only, and a source must hold its sample until it is taken.
  logic [1:0] count_q, count_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic       rdy_en_q, rdy_en_d;
  word_t      x_mem_q [2];
  word_t      x_mem_d [2];
  word_t      y_mem_q [2];
  word_t      y_mem_d [2];
  logic       q_mem_q [2];
  logic       q_mem_d [2];

  word_t x_sc, y_sc, x_wr, y_wr;
  logic  quad_wr;
  logic  push, pop;

`ifdef IP_UPSCALE_PREROT_EN
  // Only the most negative word can overflow on negation; clamp it to the largest positive value.
  function automatic word_t neg_sat(input word_t v);
    if (v == {1'b1, {(CORDIC_WIDTH-1){1'b0}}}) return {1'b0, {(CORDIC_WIDTH-1){1'b1}}};
    return -v;
  endfunction
`endif

  always_comb begin
    x_sc = word_t'($signed(x_in)) <<< SHIFT;
    y_sc = word_t'($signed(y_in)) <<< SHIFT;
`ifdef IP_UPSCALE_PREROT_EN
    quad_wr = x_in[DATA_WIDTH-1];
    x_wr    = quad_wr ? neg_sat(x_sc) : x_sc;
    y_wr    = quad_wr ? neg_sat(y_sc) : y_sc;
`else
    quad_wr = 1'b0;
    x_wr    = x_sc;
    y_wr    = y_sc;
`endif
  end

  // rdy_en_q keeps ip_rdy low until the first clock after reset release.
  assign ip_rdy   = rdy_en_q & (count_q != 2'd2);
  assign op_vld   = (count_q != 2'd0);
  assign push     = ip_vld & ip_rdy;
  assign pop      = op_vld & op_rdy;
  assign x_out    = x_mem_q[rd_ptr_q];
  assign y_out    = y_mem_q[rd_ptr_q];
  assign quad_out = q_mem_q[rd_ptr_q];

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    rdy_en_d = 1'b1;
    x_mem_d  = x_mem_q;
    y_mem_d  = y_mem_q;
    q_mem_d  = q_mem_q;
    if (clr) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push) begin
        x_mem_d[wr_ptr_q] = x_wr;
        y_mem_d[wr_ptr_q] = y_wr;
        q_mem_d[wr_ptr_q] = quad_wr;
        wr_ptr_d          = ~wr_ptr_q;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      rdy_en_q <= 1'b0;
      x_mem_q  <= '{default: '0};
      y_mem_q  <= '{default: '0};
      q_mem_q  <= '{default: 1'b0};
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rdy_en_q <= rdy_en_d;
      x_mem_q  <= x_mem_d;
      y_mem_q  <= y_mem_d;
      q_mem_q  <= q_mem_d;
    end
  end

endmodule

// File: tb/tb_ip_upscale.sv
// Bench for ip_upscale: queue-level FIFO model with arithmetic scaling reference, directed and
// randomized steps. Honors IP_UPSCALE_PREROT_EN when the design is built with it.
module tb_ip_upscale;

  localparam int CW = 22;
  localparam int DW = 16;
  localparam int GB = 2;
  localparam int EW = 2*CW + 1;

  logic          clk = 1'b0;
  logic          nreset, clr, ip_vld, op_rdy;
  logic [DW-1:0] x_in, y_in;
  logic          ip_rdy, quad_out, op_vld;
  logic [CW-1:0] x_out, y_out;
  logic          ip_rdy0, quad_out0, op_vld0;
  logic [CW-1:0] x_out0, y_out0;

  ip_upscale #(.CORDIC_WIDTH(CW), .DATA_WIDTH(DW), .GUARD_BITS(GB)) dut (
    .clk(clk), .nreset(nreset), .clr(clr), .x_in(x_in), .y_in(y_in), .ip_vld(ip_vld),
    .ip_rdy(ip_rdy), .x_out(x_out), .y_out(y_out), .quad_out(quad_out), .op_vld(op_vld),
    .op_rdy(op_rdy)
  );

  // Zero-guard instance sees the same stimulus; used for the overflow corner only.
  ip_upscale #(.CORDIC_WIDTH(CW), .DATA_WIDTH(DW), .GUARD_BITS(0)) dut_gb0 (
    .clk(clk), .nreset(nreset), .clr(clr), .x_in(x_in), .y_in(y_in), .ip_vld(ip_vld),
    .ip_rdy(ip_rdy0), .x_out(x_out0), .y_out(y_out0), .quad_out(quad_out0), .op_vld(op_vld0),
    .op_rdy(op_rdy)
  );

  // clock / reset
  always #5 clk = ~clk;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic          rdy_ok  = 1'b0;
  logic          last_push;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: signed value times 2^(CW-DW-guard), optional negation, clamp at the positive limit.
  function automatic logic [CW-1:0] scale(input logic [DW-1:0] v, input int guard, input logic neg);
    longint s;
    longint maxv;
    s = longint'($signed(v)) * (longint'(1) << (CW - DW - guard));
    if (neg) s = -s;
    maxv = (longint'(1) << (CW - 1)) - 1;
    if (s > maxv) s = maxv;
    return s[CW-1:0];
  endfunction

  function automatic logic [EW-1:0] model(input logic [DW-1:0] xi, input logic [DW-1:0] yi);
    logic neg;
    neg = 1'b0;
`ifdef IP_UPSCALE_PREROT_EN
    neg = xi[DW-1];
`endif
    return {neg, scale(xi, GB, neg), scale(yi, GB, neg)};
  endfunction

  // One cycle, entered and left at a falling edge: check outputs, drive inputs, advance model.
  task automatic step(input logic vld, input logic [DW-1:0] xi, input logic [DW-1:0] yi,
                      input logic rdy, input logic cl);
    logic          m_vld, m_rdy, push, pop;
    logic [EW-1:0] head;
    m_vld = (exp_q.size() != 0);
    m_rdy = rdy_ok && (exp_q.size() < 2);
    check("op_vld", 64'(op_vld), 64'(m_vld));
    check("ip_rdy", 64'(ip_rdy), 64'(m_rdy));
    if (m_vld) begin
      head = exp_q[0];
      check("x_out", 64'(x_out), 64'(head[EW-2 -: CW]));
      check("y_out", 64'(y_out), 64'(head[CW-1:0]));
      check("quad_out", 64'(quad_out), 64'(head[EW-1]));
    end
    ip_vld = vld;
    x_in   = xi;
    y_in   = yi;
    op_rdy = rdy;
    clr    = cl;
    push   = vld && m_rdy && !cl;
    pop    = m_vld && rdy && !cl;
    @(posedge clk);
    if (cl) exp_q.delete();
    else begin
      if (pop) void'(exp_q.pop_front());
      if (push) exp_q.push_back(model(xi, yi));
    end
    last_push = push;
    @(negedge clk);
  endtask

  task automatic send(input logic [DW-1:0] xi, input logic [DW-1:0] yi, input logic rdy);
    for (int i = 0; i < 50; i++) begin
      step(1'b1, xi, yi, rdy, 1'b0);
      if (last_push) return;
    end
    n_tests++;
    n_fail++;
    $error("FAIL send_timeout: observed no accept expected accept within 50 cycles");
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_op_vld"}, 64'(op_vld), 64'(0));
    check({tag, "_ip_rdy"}, 64'(ip_rdy), 64'(0));
    check({tag, "_x_out"}, 64'(x_out), 64'(0));
    check({tag, "_y_out"}, 64'(y_out), 64'(0));
    check({tag, "_quad"}, 64'(quad_out), 64'(0));
  endtask

  task automatic release_reset();
    @(negedge clk);
    nreset = 1'b1;
    #1;
    check("rel_ip_rdy_low", 64'(ip_rdy), 64'(0));
    @(posedge clk);
    rdy_ok = 1'b1;
    @(negedge clk);
    check("rel_ip_rdy_high", 64'(ip_rdy), 64'(1));
  endtask

  initial begin
    nreset = 1'b0;
    clr    = 1'b0;
    ip_vld = 1'b0;
    op_rdy = 1'b0;
    x_in   = '0;
    y_in   = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    release_reset();

    // Scaling corners: +max and -max; values follow directly from the bit mapping.
    step(1'b1, 16'h7FFF, 16'h8000, 1'b0, 1'b0);
    check("scale_vld", 64'(op_vld), 64'(1));
    check("scale_x", 64'(x_out), 64'(22'h07FFF0));
    check("scale_y", 64'(y_out), 64'(22'h380000));
    drain();

    // Negative x: pre-rotation visible only when built with the macro.
    step(1'b1, 16'hFFFF, 16'h0003, 1'b0, 1'b0);
`ifdef IP_UPSCALE_PREROT_EN
    check("prerot_x", 64'(x_out), 64'(22'h000010));
    check("prerot_y", 64'(y_out), 64'(22'h3FFFD0));
    check("prerot_q", 64'(quad_out), 64'(1));
`else
    check("noprerot_x", 64'(x_out), 64'(22'h3FFFF0));
    check("noprerot_y", 64'(y_out), 64'(22'h000030));
    check("noprerot_q", 64'(quad_out), 64'(0));
`endif
    drain();

    // Zero guard bits: most negative input reaches the most negative word.
    step(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b0);
    check("gb0_vld", 64'(op_vld0), 64'(1));
`ifdef IP_UPSCALE_PREROT_EN
    check("gb0_x_sat", 64'(x_out0), 64'(22'h1FFFFF));
    check("gb0_y", 64'(y_out0), 64'(22'h3FFFC0));
`else
    check("gb0_x", 64'(x_out0), 64'(22'h200000));
    check("gb0_y", 64'(y_out0), 64'(22'h000040));
`endif
    drain();

    // Backpressure: third sample held until room appears, then all drain in order.
    send(16'h1111, 16'h2222, 1'b0);
    send(16'h8333, 16'h4444, 1'b0);
    repeat (3) step(1'b1, 16'h5555, 16'hA666, 1'b0, 1'b0);
    send(16'h5555, 16'hA666, 1'b1);
    drain();

    // Streaming: full rate, occupancy stays at one.
    for (int i = 0; i < 100; i++) step(1'b1, DW'($urandom), DW'($urandom), 1'b1, 1'b0);
    drain();

    // Flush at full occupancy, and at occupancy one where the concurrent push is accepted-looking.
    send(16'h0101, 16'h0202, 1'b0);
    send(16'h0303, 16'h0404, 1'b0);
    step(1'b1, 16'h0505, 16'h0606, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    send(16'h0707, 16'h0808, 1'b0);
    step(1'b1, 16'h0909, 16'h0A0A, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // Randomized mix of valid, ready and occasional flush.
    for (int i = 0; i < 400; i++)
      step(1'(($urandom_range(0, 3)) != 0), DW'($urandom), DW'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
    drain();

    // Reset mid-transfer with two samples buffered.
    send(16'hC0DE, 16'hBEEF, 1'b0);
    send(16'h1234, 16'h8765, 1'b0);
    ip_vld = 1'b0;
    #2 nreset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    rdy_ok = 1'b0;
    release_reset();
    step(1'b0, '0, '0, 1'b1, 1'b0);
    send(16'h7F00, 16'h00FF, 1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
